// File: rtl/dsr_pkg.sv
// Shared types and constants for the data SRAM responder.
package dsr_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = 4;
  localparam int unsigned CNT_WIDTH  = 4;

  // All-zero strobes mark a load; any other pattern is a store.
  localparam logic [STRB_WIDTH-1:0] LOAD_STRB = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dsr_state_e;

endpackage

// File: rtl/dsr_mem_array.sv
// Byte-writable word array with registered read; contents are never reset.
module dsr_mem_array
  import dsr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [STRB_WIDTH-1:0] we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-lane write on stores, registered read on loads.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (we == LOAD_STRB) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Single-outstanding load/store responder with programmable wait states and pipeline stall.
module data_sram_responder
  import dsr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall_req
);

  dsr_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept, enter_resp, leave_resp;

  logic [ADDR_WIDTH-1:0] hold_word;
  logic [STRB_WIDTH-1:0] hold_wstrb;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic                  hold_err;

  logic [ADDR_WIDTH-1:0] acc_word;
  logic [STRB_WIDTH-1:0] acc_wstrb;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_err;
  logic                  req_oor;

  logic                  resp_load_q, resp_err_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            unused_addr_lsb;

  assign unused_addr_lsb = req_addr[1:0];
  assign req_oor         = |req_addr[31:ADDR_WIDTH+2];

  // Next-state, counter and stall decode; counter is loaded so RESP is entered
  // WAIT_CYCLES+1 edges after acceptance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    stall_req  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_req = req_valid;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_WIDTH'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        stall_req = 1'b1;
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        stall_req = ~resp_ready;
        if (resp_ready) begin
          state_d    = ST_IDLE;
          leave_resp = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array access uses live request fields when RESP is entered straight from IDLE.
  assign acc_word  = (state_q == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : hold_word;
  assign acc_wstrb = (state_q == ST_IDLE) ? req_wstrb : hold_wstrb;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : hold_wdata;
  assign acc_err   = (state_q == ST_IDLE) ? req_oor   : hold_err;

  // State, counter, request holding and response flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_word   <= '0;
      hold_wstrb  <= '0;
      hold_wdata  <= '0;
      hold_err    <= 1'b0;
      resp_load_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        hold_word  <= req_addr[ADDR_WIDTH+1:2];
        hold_wstrb <= req_wstrb;
        hold_wdata <= req_wdata;
        hold_err   <= req_oor;
      end
      if (enter_resp) begin
        resp_err_q  <= acc_err;
        resp_load_q <= ~acc_err & (acc_wstrb == LOAD_STRB);
      end else if (leave_resp) begin
        resp_err_q  <= 1'b0;
        resp_load_q <= 1'b0;
      end
    end
  end

  dsr_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .en   (enter_resp & ~acc_err),
    .we   (acc_wstrb),
    .addr (acc_word),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_load_q ? mem_rdata : '0;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed table, reset corners,
// zero-wait throughput and randomized traffic against a word-array model.
module tb_data_sram_responder;

  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, stall_req;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata, resp_rdata;

  logic        z_req_valid, z_req_ready, z_resp_valid, z_resp_ready, z_resp_err, z_stall_req;
  logic [3:0]  z_req_wstrb;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wstrb(req_wstrb),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall_req(stall_req)
  );

  data_sram_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wstrb(z_req_wstrb),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .stall_req(z_stall_req)
  );

  typedef struct {
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  logic [31:0] model [8];
  logic [31:0] zaddr [4];
  logic [31:0] zdata [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one request in IDLE; returns one step after the acceptance edge.
  task automatic issue(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata);
    req_wstrb = strb;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  // Count edges from acceptance until resp_valid, checking WAIT behaviour.
  task automatic wait_resp(output int k);
    k = 0;
    while (!resp_valid && k < 40) begin
      chk("wait_stall", 32'(stall_req), 32'd1);
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      k++;
    end
  endtask

  // Hold the response for 'hold' cycles, then consume it and check the IDLE gap.
  task automatic finish_resp(input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      chk("resp_stall_held", 32'(stall_req), 32'd1);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    #1;
    chk("resp_stall_release", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("gap_req_ready", 32'(req_ready), 32'd1);
    chk("gap_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic run_txn(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    int k;
    issue(strb, addr, wdata);
    wait_resp(k);
    chk("latency", 32'(k), 32'(WC + 1));
    finish_resp(hold, exp_rdata, exp_err);
  endtask

  // Zero-wait instance: four back-to-back requests with resp_ready held high.
  task automatic z_burst(input logic [3:0] strb);
    int idx;
    idx = 0;
    z_req_wstrb  = strb;
    z_req_addr   = zaddr[0];
    z_req_wdata  = zdata[0];
    z_req_valid  = 1'b1;
    z_resp_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 1) begin
        chk("z_resp_valid", 32'(z_resp_valid), 32'd1);
        chk("z_resp_stall", 32'(z_stall_req), 32'd0);
        if (z_resp_valid && idx < 4) begin
          chk("z_rdata", z_resp_rdata, (strb == 4'b0000) ? zdata[idx] : 32'h0);
          idx++;
          if (idx < 4) begin
            z_req_addr  = zaddr[idx];
            z_req_wdata = zdata[idx];
          end else begin
            z_req_valid = 1'b0;
          end
        end
      end else begin
        chk("z_gap_resp_valid", 32'(z_resp_valid), 32'd0);
        chk("z_gap_stall", 32'(z_stall_req), 32'(z_req_valid));
      end
    end
    chk("z_resp_count", 32'(idx), 32'd4);
    z_resp_ready = 1'b0;
  endtask

  initial begin
    int          k;
    logic        seen;
    logic [3:0]  strb;
    logic [31:0] addr, wdata, exp_rdata;
    logic        exp_err;
    int          w;

    reset = 1'b0;
    req_valid = 1'b0; req_wstrb = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_wstrb = '0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;

    vecs[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
    vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{4'h2, 32'h0000_0010, 32'h0000_AA00, 0, 32'h0,         1'b0};
    vecs[3]  = '{4'h0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_AAEF, 1'b0};
    vecs[4]  = '{4'hF, 32'h0000_0000, 32'h0123_4567, 0, 32'h0,         1'b0};
    vecs[5]  = '{4'h0, 32'h0000_4000, 32'h0,         0, 32'h0,         1'b1};
    vecs[6]  = '{4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 0, 32'h0,         1'b1};
    vecs[7]  = '{4'h0, 32'h0000_0000, 32'h0,         0, 32'h0123_4567, 1'b0};
    vecs[8]  = '{4'h0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_AAEF, 1'b0};
    vecs[9]  = '{4'hA, 32'h0000_0010, 32'h1122_3344, 0, 32'h0,         1'b0};
    vecs[10] = '{4'h0, 32'h0000_0013, 32'h0,         1, 32'h11AD_33EF, 1'b0};
    vecs[11] = '{4'hF, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h0,         1'b0};
    vecs[12] = '{4'h0, 32'h0000_0020, 32'h0,         2, 32'hCAFE_F00D, 1'b0};
    vecs[13] = '{4'h0, 32'h8000_0004, 32'h0,         0, 32'h0,         1'b1};
    vecs[14] = '{4'hF, 32'h0000_3FFC, 32'h0BAD_F00D, 0, 32'h0,         1'b0};
    vecs[15] = '{4'h0, 32'h0000_3FFC, 32'h0,         0, 32'h0BAD_F00D, 1'b0};

    zaddr = '{32'h190, 32'h194, 32'h198, 32'h19C};
    zdata = '{32'hA1B2_C3D4, 32'h5566_7788, 32'h0F0F_F0F0, 32'h1357_9BDF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_stall_low", 32'(stall_req), 32'd0);
    req_valid = 1'b1;
    #1;
    chk("rst_stall_follow", 32'(stall_req), 32'd1);
    req_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NVEC; i++)
      run_txn(vecs[i].strb, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
              vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset during WAIT of a store: no response, no write
    issue(4'hF, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("rstw_no_resp", 32'(seen), 32'd0);
    run_txn(4'h0, 32'h0000_0020, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset during RESP of a store: response dropped, write kept
    issue(4'hF, 32'h0000_0024, 32'h55AA_55AA);
    wait_resp(k);
    chk("rstr_resp_valid", 32'(resp_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstr_dropped", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_txn(4'h0, 32'h0000_0024, 32'h0, 0, 32'h55AA_55AA, 1'b0);

    // Zero-wait throughput: stores then loads, one response every 2 cycles
    z_burst(4'hF);
    @(posedge clk); #1;
    z_burst(4'h0);

    // Randomized traffic against a word-array model (words 64..71)
    for (int i = 0; i < 8; i++) begin
      wdata = $urandom;
      run_txn(4'hF, 32'((64 + i) * 4), wdata, 0, 32'h0, 1'b0);
      model[i] = wdata;
    end
    for (int n = 0; n < 40; n++) begin
      w     = int'($urandom_range(0, 7));
      wdata = $urandom;
      strb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        addr = $urandom;
        if (addr[31:14] == 18'h0) addr[31] = 1'b1;
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
      end else begin
        addr      = 32'((64 + w) * 4) | 32'($urandom_range(0, 3));
        exp_err   = 1'b0;
        exp_rdata = (strb == 4'h0) ? model[w] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[w][8*b +: 8] = wdata[8*b +: 8];
      end
      run_txn(strb, addr, wdata, int'($urandom_range(0, 3)), exp_rdata, exp_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
